// File: rtl/dsp_alu_arbiter_pkg.sv
// Shared types and DSP48E2 control encodings for the DSP ALU arbiter.
// Maps each client op onto the ALUMODE/OPMODE pair that realises it on C and A:B.
package dsp_alu_arbiter_pkg;

  typedef enum logic [1:0] {
    OpAnd = 2'd0,
    OpOr  = 2'd1,
    OpXor = 2'd2,
    OpSub = 2'd3
  } op_e;

  typedef struct packed {
    logic [3:0] alumode;
    logic [8:0] opmode;
  } dsp_ctrl_t;

  localparam logic [3:0] AluAnd = 4'b1100;
  localparam logic [3:0] AluOr  = 4'b1100;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluSub = 4'b0011;

  // X = A:B, Z = C; OR differs from AND only in OPMODE[3:2]
  localparam logic [8:0] OpmAnd = 9'b000110011;
  localparam logic [8:0] OpmOr  = 9'b000111011;
  localparam logic [8:0] OpmXor = 9'b000110011;
  localparam logic [8:0] OpmSub = 9'b000110011;

  function automatic dsp_ctrl_t op_ctrl(op_e op);
    dsp_ctrl_t ctrl;
    unique case (op)
      OpAnd: ctrl = '{alumode: AluAnd, opmode: OpmAnd};
      OpOr:  ctrl = '{alumode: AluOr,  opmode: OpmOr};
      OpXor: ctrl = '{alumode: AluXor, opmode: OpmXor};
      OpSub: ctrl = '{alumode: AluSub, opmode: OpmSub};
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/dsp_alu_rsp_fifo.sv
// Response buffer for the DSP ALU arbiter: DEPTH-entry FIFO, non-power-of-two safe.
// Push and pop in the same cycle are accepted even when full.
module dsp_alu_rsp_fifo #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 50,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dsp_alu_arbiter.sv
// Round-robin arbiter sharing one DSP48E2 ALU among NREQ requesters, credit-limited.
// Define DSP_ALU_ARBITER_STATS_EN to add the stat_issue/stat_stall counters.
module dsp_alu_arbiter
  import dsp_alu_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 48,
  parameter int unsigned LAT   = 1,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic [47:0]           dsp_c,
  output logic [47:0]           dsp_ab,
  output logic [3:0]            dsp_alumode,
  output logic [8:0]            dsp_opmode,
  input  logic [WIDTH-1:0]      dsp_y
`ifdef DSP_ALU_ARBITER_STATS_EN
  ,
  output logic [31:0]           stat_issue,
  output logic [31:0]           stat_stall
`endif
);

  localparam int unsigned DEPTH  = LAT + 2;
  localparam int unsigned Stages = (LAT > 0) ? LAT : 1;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned OccW   = CntW + 1;
  localparam int unsigned EntW   = WIDTH + IDW;

  logic [IDW-1:0]             ptr_q, ptr_d, winner;
  logic [IDW:0]               cand;
  logic                       found, credit_ok, grant, issue, pop;
  logic [Stages-1:0]          tag_valid_q;
  logic [Stages-1:0][IDW-1:0] tag_id_q;
  logic                       exit_valid;
  logic [IDW-1:0]             exit_id;
  logic [CntW-1:0]            fifo_count;
  logic                       fifo_full, fifo_empty;
  logic [EntW-1:0]            fifo_head;
  logic [OccW-1:0]            occ;
  op_e                        sel_op;
  logic [WIDTH-1:0]           sel_a, sel_b;
  dsp_ctrl_t                  ctrl;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (IDW + 1)'(ptr_q) + (IDW + 1)'(k);
      if (cand >= (IDW + 1)'(NREQ)) cand = cand - (IDW + 1)'(NREQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_op = OpAnd;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_op = op_e'(req_op[2*i +: 2]);
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Credit counts results still in the DSP pipe plus those already buffered
  always_comb begin
    occ = OccW'(fifo_count);
    for (int unsigned s = 0; s < Stages; s++) occ = occ + OccW'(tag_valid_q[s]);
  end

  assign pop       = rsp_valid & rsp_ready;
  assign credit_ok = (occ < OccW'(DEPTH)) | ((occ == OccW'(DEPTH)) & pop);
  assign grant     = found & credit_ok;
  // Flops are held by reset anyway; only the visible outputs need the gate
  assign issue     = grant & reset;
  assign ptr_d     = !grant ? ptr_q : (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready   = '0;
    dsp_c       = '0;
    dsp_ab      = '0;
    dsp_alumode = '0;
    dsp_opmode  = '0;
    ctrl        = op_ctrl(sel_op);
    if (issue) begin
      req_ready[winner] = 1'b1;
      dsp_c             = 48'(sel_a);
      dsp_ab            = 48'(sel_b);
      dsp_alumode       = ctrl.alumode;
      dsp_opmode        = ctrl.opmode;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (LAT > 0) begin
        tag_valid_q[0] <= grant;
        tag_id_q[0]    <= winner;
        for (int unsigned s = 1; s < Stages; s++) begin
          tag_valid_q[s] <= tag_valid_q[s-1];
          tag_id_q[s]    <= tag_id_q[s-1];
        end
      end
    end
  end

  assign exit_valid = (LAT == 0) ? grant  : tag_valid_q[Stages-1];
  assign exit_id    = (LAT == 0) ? winner : tag_id_q[Stages-1];

  dsp_alu_rsp_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EntW)
  ) u_rsp_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (exit_valid),
    .push_data({exit_id, dsp_y}),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_data  = fifo_empty ? '0 : fifo_head[WIDTH-1:0];
  assign rsp_id    = fifo_empty ? '0 : fifo_head[EntW-1 -: IDW];

  no_overflow_a: assert property (@(posedge clock) disable iff (!reset)
    !(fifo_full && exit_valid && !pop));

`ifdef DSP_ALU_ARBITER_STATS_EN
  logic [31:0] stat_issue_q, stat_stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (grant) stat_issue_q <= stat_issue_q + 32'd1;
      if (|req_valid && !grant) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issue = stat_issue_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_dsp_alu_arbiter.sv
// Self-checking bench for dsp_alu_arbiter: vector table, scoreboard and corner-case sequences.
// Stats checks compile in when DSP_ALU_ARBITER_STATS_EN is defined.
module tb_dsp_alu_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 48;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = LAT + 2;
  localparam int unsigned IDW   = 2;

  typedef struct {
    int unsigned      id;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic [47:0]           dsp_c, dsp_ab;
  logic [3:0]            dsp_alumode;
  logic [8:0]            dsp_opmode;
  logic [WIDTH-1:0]      dsp_y = '0;
`ifdef DSP_ALU_ARBITER_STATS_EN
  logic [31:0]           stat_issue, stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  logic [NREQ-1:0]       acc_mask;
  logic                  pop_seen;
  logic [IDW+WIDTH-1:0]  pop_word;
  logic [IDW+WIDTH-1:0]  sb[$];
  int                    grant_log[$];
  vec_t                  vecs[8];

  always #5 clock = ~clock;

  dsp_alu_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .LAT  (LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .dsp_c      (dsp_c),
    .dsp_ab     (dsp_ab),
    .dsp_alumode(dsp_alumode),
    .dsp_opmode (dsp_opmode),
    .dsp_y      (dsp_y)
`ifdef DSP_ALU_ARBITER_STATS_EN
    ,
    .stat_issue (stat_issue),
    .stat_stall (stat_stall)
`endif
  );

  // Behavioural DSP48E2 with one P register, decoding only the modes the arbiter uses
  function automatic logic [WIDTH-1:0] dsp_model(logic [47:0] c, logic [47:0] ab,
                                                 logic [3:0] alu, logic [8:0] opm);
    logic [47:0] r;
    case ({alu, opm})
      {4'b1100, 9'b000110011}: r = c & ab;
      {4'b1100, 9'b000111011}: r = c | ab;
      {4'b0100, 9'b000110011}: r = c ^ ab;
      {4'b0011, 9'b000110011}: r = c - ab;
      default:                 r = '0;
    endcase
    return r[WIDTH-1:0];
  endfunction

  always @(posedge clock) dsp_y <= dsp_model(dsp_c, dsp_ab, dsp_alumode, dsp_opmode);

  function automatic logic [WIDTH-1:0] ref_alu(logic [1:0] op, logic [WIDTH-1:0] a,
                                               logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a - b;
    endcase
  endfunction

  function automatic logic [12:0] ref_ctrl(logic [1:0] op);
    case (op)
      2'd0:    return {4'b1100, 9'b000110011};
      2'd1:    return {4'b1100, 9'b000111011};
      2'd2:    return {4'b0100, 9'b000110011};
      default: return {4'b0011, 9'b000110011};
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then return just after the rising edge
  task automatic cycle();
    @(negedge clock);
    acc_mask = '0;
    if (reset) begin
      acc_mask = req_valid & req_ready;
      chk("ready_legal", {62'd0, $onehot0(req_ready), ((req_ready & ~req_valid) == '0)}, 64'd3);
      if (acc_mask == '0) begin
        chk("idle_dsp", {63'd0, |{dsp_c, dsp_ab, dsp_alumode, dsp_opmode}}, 64'd0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          sb.push_back({IDW'(i), ref_alu(req_op[2*i +: 2], req_a[WIDTH*i +: WIDTH],
                                         req_b[WIDTH*i +: WIDTH])});
          chk("issue_ctrl", {dsp_alumode, dsp_opmode}, ref_ctrl(req_op[2*i +: 2]));
          chk("issue_c", dsp_c, 48'(req_a[WIDTH*i +: WIDTH]));
          chk("issue_ab", dsp_ab, 48'(req_b[WIDTH*i +: WIDTH]));
          grant_log.push_back(i);
          n_acc++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        pop_seen = 1'b1;
        pop_word = {rsp_id, rsp_data};
        n_pop++;
        chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) chk("rsp_word", pop_word, sb.pop_front());
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(int i, logic [1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    req_op[2*i +: 2]      = op;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 30 && (sb.size() != 0 || rsp_valid); k++) cycle();
    chk("drain_empty", sb.size(), 0);
    chk("drain_rsp_valid", rsp_valid, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    sb.delete();
  endtask

  initial begin
    automatic int          lat;
    automatic int          id;
    automatic logic        got;
    automatic logic [WIDTH-1:0] bp_a;

    vecs[0] = '{0, 2'd0, 48'hF0F0,         48'hFF00,         48'hF000};
    vecs[1] = '{1, 2'd1, 48'h1,            48'h2,            48'h3};
    vecs[2] = '{2, 2'd2, 48'hABC,          48'hABC,          48'h0};
    vecs[3] = '{3, 2'd3, 48'h0,            48'h1,            48'hFFFF_FFFF_FFFF};
    vecs[4] = '{0, 2'd3, 48'd10,           48'd3,            48'd7};
    vecs[5] = '{1, 2'd0, 48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC};
    vecs[6] = '{2, 2'd2, 48'hFFFF_0000_0000, 48'h0000_FFFF_0000, 48'hFFFF_FFFF_0000};
    vecs[7] = '{3, 2'd1, 48'h8000_0000_0000, 48'h0000_0000_0001, 48'h8000_0000_0001};

    req_valid = '1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    pop_seen  = 1'b0;
    pop_word  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    req_valid = '0;
    reset = 1'b1;

    // Round robin from ptr 0, all requesters saturating
    for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 48'h100 + 48'(i), 48'(i + 1));
    rsp_ready = 1'b1;
    req_valid = '1;
    grant_log.delete();
    repeat (8) cycle();
    req_valid = '0;
    chk("rr_count", grant_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant", (k < grant_log.size()) ? grant_log[k] : -1, k % NREQ);
    end
    drain();

    // Vector table: one op at a time, with fixed latency
    for (int v = 0; v < 8; v++) begin
      id = vecs[v].id;
      set_req(id, vecs[v].op, vecs[v].a, vecs[v].b);
      req_valid[id] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        cycle();
        got = acc_mask[id];
      end
      req_valid[id] = 1'b0;
      chk("vec_accept", got, 1);
      lat = 0;
      pop_seen = 1'b0;
      for (int k = 0; k < 10 && !pop_seen; k++) begin
        cycle();
        lat++;
      end
      chk("vec_latency", lat, LAT + 1);
      chk("vec_data", pop_word[WIDTH-1:0], vecs[v].exp);
      chk("vec_id", pop_word[WIDTH +: IDW], id);
    end
    drain();

    // Backpressure: credit caps accepts at DEPTH, one pop frees exactly one
    rsp_ready = 1'b0;
    bp_a = 48'd100;
    set_req(1, 2'd3, bp_a, 48'd1);
    req_valid = 4'b0010;
    n_acc = 0;
    n_pop = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (acc_mask[1]) begin
        bp_a++;
        set_req(1, 2'd3, bp_a, 48'd1);
      end
    end
    chk("bp_accepts", n_acc, DEPTH);
    chk("bp_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    chk("bp_pop_accept", acc_mask, 4'b0010);
    if (acc_mask[1]) begin
      bp_a++;
      set_req(1, 2'd3, bp_a, 48'd1);
    end
    repeat (5) cycle();
    chk("bp_accepts_after_pop", n_acc, DEPTH + 1);
    req_valid = '0;
    drain();
    chk("bp_pops", n_pop, DEPTH + 1);

    // Reset with ops in flight and buffered
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    n_acc = 0;
    for (int k = 0; k < 10 && n_acc < 3; k++) cycle();
    chk("mid_accepts", n_acc, 3);
    chk("mid_rsp_valid_before", rsp_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_rsp_valid_async", rsp_valid, 0);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_rsp_data", rsp_data, 0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    chk("mid_req_ready_held", req_ready, 0);
    reset = 1'b1;
    req_valid = '0;
    cycle();
    cycle();
    chk("mid_fifo_empty", rsp_valid, 0);
    req_valid = '1;
    cycle();
    req_valid = '0;
    chk("mid_first_grant", acc_mask, 4'b0001);
    drain();

`ifdef DSP_ALU_ARBITER_STATS_EN
    pulse_reset();
    set_req(1, 2'd1, 48'h5, 48'h6);
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    n_acc = 0;
    for (int k = 0; k < 10 && n_acc < 2; k++) cycle();
    req_valid = '0;
    drain();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 10 && n_acc < 5; k++) cycle();
    repeat (3) cycle();
    req_valid = '0;
    chk("stat_issue", stat_issue, 5);
    chk("stat_stall", stat_stall, 3);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
